// File: rtl/spi_tx_shift_register.sv
// rtl/spi_tx_shift_register.sv - SPI master transmit shift register
//
// Purpose:
//   Captures a parallel word of up to 128 bits and serialises it onto mosi,
//   MSB-first or LSB-first, advancing one bit per shift_stb from the SCLK
//   generator. Signals completion to the master control FSM and mirrors the
//   receive shift register's char_len / lsb / go_busy handshake.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high
//   char_len     transfer length in bits, 1..127 literal, 0 means 128
//   lsb          0 = MSB-first, 1 = LSB-first
//   txd          parallel transmit data, bits [N-1:0] used
//   load         capture txd into the data register (IDLE only)
//   go_busy      level-sensitive transfer request / enable
//   shift_stb    one-cycle strobe advancing mosi to the next bit
//   mosi         registered serial data out
//   tx_complete  high from end of last bit until go_busy drops
//   busy         high while a transfer is in progress
//   bits_left    bits not yet completed, 0..128
//
// Configuration:
//   SPI_TX_MOSI_IDLE_LOW_EN
//     defined   : mosi is 0 in IDLE and DONE, carries data only in ACTIVE
//     undefined : in IDLE mosi presents the would-be first bit of the data
//                 register (current lsb/char_len); in DONE it holds the last
//                 transmitted bit

module spi_tx_shift_register (
  input  logic         clk,
  input  logic         reset,
  input  logic [6:0]   char_len,
  input  logic         lsb,
  input  logic [127:0] txd,
  input  logic         load,
  input  logic         go_busy,
  input  logic         shift_stb,
  output logic         mosi,
  output logic         tx_complete,
  output logic         busy,
  output logic [7:0]   bits_left
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [127:0] data;
  logic [127:0] data_next;
  logic [6:0]   idx;            // index of the bit currently on mosi
  logic [6:0]   idx_next;
  logic         lsb_lat;        // bit order frozen for the whole transfer
  logic         lsb_lat_next;
  logic [7:0]   bits_left_next;
  logic         mosi_next;
  logic         tx_complete_next;

  logic [6:0]   first_idx;
  logic [7:0]   len_dec;
  logic         idle_mosi;
  logic         done_mosi;

  // Length decode. For MSB-first the first index is N-1; the 7-bit
  // subtraction wraps 0 (meaning 128) to 127 naturally.
  assign len_dec   = (char_len == 7'd0) ? 8'd128 : {1'b0, char_len};
  assign first_idx = lsb ? 7'd0 : (char_len - 7'd1);

  // The data register only accepts new data while idle; when load and
  // go_busy coincide, the transfer must start from the freshly loaded txd.
  assign data_next = ((state == IDLE) && load) ? txd : data;

`ifdef SPI_TX_MOSI_IDLE_LOW_EN
  assign idle_mosi = 1'b0;
  assign done_mosi = 1'b0;
`else
  assign idle_mosi = data_next[first_idx];
  assign done_mosi = mosi;
`endif

  assign busy = (state == ACTIVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      data        <= '0;
      idx         <= '0;
      lsb_lat     <= 1'b0;
      bits_left   <= '0;
      mosi        <= 1'b0;
      tx_complete <= 1'b0;
    end else begin
      state       <= state_next;
      data        <= data_next;
      idx         <= idx_next;
      lsb_lat     <= lsb_lat_next;
      bits_left   <= bits_left_next;
      mosi        <= mosi_next;
      tx_complete <= tx_complete_next;
    end
  end

  always_comb begin
    state_next       = state;
    idx_next         = idx;
    lsb_lat_next     = lsb_lat;
    bits_left_next   = bits_left;
    mosi_next        = mosi;
    tx_complete_next = tx_complete;

    case (state)
      IDLE: begin
        mosi_next        = idle_mosi;
        bits_left_next   = 8'd0;
        tx_complete_next = 1'b0;
        if (go_busy) begin
          state_next     = ACTIVE;
          idx_next       = first_idx;
          lsb_lat_next   = lsb;
          bits_left_next = len_dec;
          mosi_next      = data_next[first_idx];
        end
      end

      ACTIVE: begin
        if (!go_busy) begin
          // Abort: no completion is reported.
          state_next     = IDLE;
          bits_left_next = 8'd0;
          mosi_next      = idle_mosi;
        end else if (shift_stb) begin
          if (bits_left > 8'd1) begin
            idx_next       = lsb_lat ? (idx + 7'd1) : (idx - 7'd1);
            bits_left_next = bits_left - 8'd1;
            mosi_next      = data[idx_next];
          end else begin
            // Strobe ending the last bit: mosi is not advanced past N-1/0.
            state_next       = DONE;
            bits_left_next   = 8'd0;
            tx_complete_next = 1'b1;
            mosi_next        = done_mosi;
          end
        end
      end

      DONE: begin
        mosi_next        = done_mosi;
        bits_left_next   = 8'd0;
        tx_complete_next = 1'b1;
        if (!go_busy) begin
          state_next       = IDLE;
          tx_complete_next = 1'b0;
          mosi_next        = idle_mosi;
        end
      end

      default: begin
        state_next       = IDLE;
        bits_left_next   = 8'd0;
        tx_complete_next = 1'b0;
        mosi_next        = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_tx_shift_register.sv
// tb/tb_spi_tx_shift_register.sv - self-checking bench for spi_tx_shift_register

module tb_spi_tx_shift_register;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [6:0]   char_len = '0;
  logic         lsb = 1'b0;
  logic [127:0] txd = '0;
  logic         load = 1'b0;
  logic         go_busy = 1'b0;
  logic         shift_stb = 1'b0;
  logic         mosi;
  logic         tx_complete;
  logic         busy;
  logic [7:0]   bits_left;

  int total = 0;
  int bad = 0;

  // Transfer-level model: which word, how long, which order, how many bits
  // have been completed. 0 = idle, 1 = active, 2 = done.
  int           m_st = 0;
  logic [127:0] m_word = '0;
  int           m_n = 0;
  int           m_pos = 0;
  logic         m_lsb = 1'b0;

  logic [127:0] got;
  int           ones;
  int           premature;
  logic         first_bit;
  logic         last_bit;

  spi_tx_shift_register dut (
    .clk         (clk),
    .reset       (reset),
    .char_len    (char_len),
    .lsb         (lsb),
    .txd         (txd),
    .load        (load),
    .go_busy     (go_busy),
    .shift_stb   (shift_stb),
    .mosi        (mosi),
    .tx_complete (tx_complete),
    .busy        (busy),
    .bits_left   (bits_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    case (m_st)
      0: begin
        if (load) m_word = txd;
        if (go_busy) begin
          m_st  = 1;
          m_n   = (char_len == 7'd0) ? 128 : int'(char_len);
          m_lsb = lsb;
          m_pos = 0;
        end
      end
      1: begin
        if (!go_busy) m_st = 0;
        else if (shift_stb) begin
          m_pos++;
          if (m_pos == m_n) m_st = 2;
        end
      end
      default: if (!go_busy) m_st = 0;
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (!reset) model_edge();
  endtask

  task automatic grab();
    got = {got[126:0], mosi};
  endtask

  // Per-cycle comparison against the model, half a period after each edge.
  always @(negedge clk) begin
    logic [6:0] bi;
    chk("busy", 128'(busy), 128'(m_st == 1));
    chk("tx_complete", 128'(tx_complete), 128'(m_st == 2));
    chk("bits_left", 128'(bits_left), (m_st == 1) ? 128'(m_n - m_pos) : 128'd0);
    if (m_st == 1) begin
      bi = 7'(m_lsb ? m_pos : (m_n - 1 - m_pos));
      chk("mosi_active", 128'(mosi), 128'(m_word[bi]));
    end else if (m_st == 2) begin
`ifdef SPI_TX_MOSI_IDLE_LOW_EN
      chk("mosi_done", 128'(mosi), 128'd0);
`else
      bi = 7'(m_lsb ? (m_n - 1) : 0);
      chk("mosi_done", 128'(mosi), 128'(m_word[bi]));
`endif
    end
`ifdef SPI_TX_MOSI_IDLE_LOW_EN
    else chk("mosi_idle", 128'(mosi), 128'd0);
`endif
  end

  initial begin
    // Reset
    cyc();
    cyc();
    chk("rst_mosi", 128'(mosi), 128'd0);
    chk("rst_tx_complete", 128'(tx_complete), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_bits_left", 128'(bits_left), 128'd0);
    reset = 1'b0;
    cyc();

    // MSB-first, load and go_busy together, back-to-back strobes
    char_len = 7'd8; lsb = 1'b0; txd = 128'hC1; load = 1'b1; go_busy = 1'b1;
    cyc();
    load = 1'b0;
    chk("msb_bits_left_start", 128'(bits_left), 128'd8);
    got = '0;
    grab();
    shift_stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i < 7) grab();
    end
    shift_stb = 1'b0;
    chk("msb_sequence", 128'(got[7:0]), 128'hC1);
    chk("msb_tx_complete", 128'(tx_complete), 128'd1);
    go_busy = 1'b0;
    cyc();
    chk("msb_complete_clears", 128'(tx_complete), 128'd0);

    // LSB-first, strobe at entry ignored, gapped strobes, late lsb/char_len changes
    txd = 128'hC1; load = 1'b1;
    cyc();
    load = 1'b0; lsb = 1'b1; go_busy = 1'b1; shift_stb = 1'b1;
    cyc();
    shift_stb = 1'b0; lsb = 1'b0; char_len = 7'd3;
    chk("lsb_bits_left_start", 128'(bits_left), 128'd8);
    got = '0;
    grab();
    for (int i = 0; i < 8; i++) begin
      shift_stb = 1'b1;
      cyc();
      shift_stb = 1'b0;
      if (i < 7) grab();
      cyc();
    end
    chk("lsb_sequence", 128'(got[7:0]), 128'h83);
    chk("lsb_bits_left_end", 128'(bits_left), 128'd0);
    chk("lsb_tx_complete", 128'(tx_complete), 128'd1);
    go_busy = 1'b0;
    cyc();

    // Full 128-bit length
    char_len = 7'd0; lsb = 1'b0; txd = {1'b1, 126'b0, 1'b1}; load = 1'b1; go_busy = 1'b1;
    cyc();
    load = 1'b0;
    chk("full_bits_left_start", 128'(bits_left), 128'd128);
    ones = 0; premature = 0; first_bit = mosi; last_bit = 1'b0;
    shift_stb = 1'b1;
    for (int i = 0; i < 128; i++) begin
      ones += int'(mosi);
      last_bit = mosi;
      cyc();
      if (i < 127 && tx_complete) premature++;
    end
    shift_stb = 1'b0;
    chk("full_first_bit", 128'(first_bit), 128'd1);
    chk("full_last_bit", 128'(last_bit), 128'd1);
    chk("full_ones", 128'(ones), 128'd2);
    chk("full_premature_done", 128'(premature), 128'd0);
    chk("full_tx_complete", 128'(tx_complete), 128'd1);
    go_busy = 1'b0;
    cyc();

    // Ignored load during ACTIVE, then abort, then resend original word
    char_len = 7'd8; txd = 128'h5A; load = 1'b1; go_busy = 1'b1;
    cyc();
    load = 1'b0; shift_stb = 1'b1;
    repeat (3) cyc();
    shift_stb = 1'b0; txd = 128'hFF; load = 1'b1;
    cyc();
    load = 1'b0; shift_stb = 1'b1;
    repeat (2) cyc();
    shift_stb = 1'b0; go_busy = 1'b0;
    cyc();
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_tx_complete", 128'(tx_complete), 128'd0);
    chk("abort_bits_left", 128'(bits_left), 128'd0);
    cyc();
    go_busy = 1'b1;
    cyc();
    got = '0;
    grab();
    shift_stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i < 7) grab();
    end
    shift_stb = 1'b0;
    chk("resend_sequence", 128'(got[7:0]), 128'h5A);
    go_busy = 1'b0;
    cyc();

    // Asynchronous reset mid-transfer, then a 4-bit transfer
    char_len = 7'd16; txd = 128'hBEEF; load = 1'b1; go_busy = 1'b1;
    cyc();
    load = 1'b0; shift_stb = 1'b1;
    repeat (5) cyc();
    shift_stb = 1'b0;
    #2;
    reset = 1'b1;
    m_st = 0; m_word = '0; m_pos = 0;
    #1;
    chk("midrst_mosi", 128'(mosi), 128'd0);
    chk("midrst_tx_complete", 128'(tx_complete), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_bits_left", 128'(bits_left), 128'd0);
    go_busy = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    char_len = 7'd4; txd = 128'hA; load = 1'b1; go_busy = 1'b1;
    cyc();
    load = 1'b0;
    got = '0;
    grab();
    shift_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i < 3) grab();
    end
    shift_stb = 1'b0;
    chk("after_rst_sequence", 128'(got[3:0]), 128'hA);
    chk("after_rst_tx_complete", 128'(tx_complete), 128'd1);
    go_busy = 1'b0;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
